pc_unit: RTL and testbench

- Parametrised program-counter stage: successor to the fixed 32-bit, +4, stop-or-increment next-PC logic.
- Holds the PC in a register and supports stall and halt/resume.
- Accepts redirects (branch/jump) at any time; redirects arriving while stalled or halted are remembered.
- Optionally includes a return-address stack (RAS).
- Sits at the head of the fetch path and drives the instruction-memory address.

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_ras.sv | 61 ++++++
 rtl/pc_unit.sv | 138 +++++++++++++
 tb/tb_pc_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and default constants for the program-counter stage.
// Latency: n/a (declarations only). Backpressure: n/a.
// Optional return-address stack is enabled with the PC_RAS_EN macro.
package pc_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        HALT  = 2'd2
    } pc_state_t;

    localparam int          PC_W_DEF      = 32;
    localparam int          STEP_DEF      = 4;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; when full, a push overwrites the oldest entry.
// Latency: top is combinational, push/pop take effect at the next edge.
// Backpressure: none; overflow and empty pops raise a one-cycle err pulse.
module pc_ras #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full,
    output logic         err
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] sp;
    logic [AW:0]   cnt;

    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(DEPTH));
    // sp points at the next free slot, so the top lives one below it
    assign top   = mem[sp - AW'(1)];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[sp] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp  <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else begin
            err <= 1'b0;
            if (push) begin
                sp <= sp + AW'(1);
                if (full) begin
                    err <= 1'b1;
                end else begin
                    cnt <= cnt + (AW+1)'(1);
                end
            end else if (pop) begin
                if (empty) begin
                    err <= 1'b1;
                end else begin
                    sp  <= sp - AW'(1);
                    cnt <= cnt - (AW+1)'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage with stall, halt/resume and remembered redirects; RAS under PC_RAS_EN.
// Latency: redirect reaches pc one cycle after it is presented on an advancing cycle.
// Backpressure: stall/halt hold pc; redirects seen while held are kept (latest wins).
module pc_unit
    import pc_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEF,
    parameter int              STEP      = STEP_DEF,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            redir_valid,
    input  logic [PC_W-1:0] redir_target,
    input  logic            call,
    input  logic            ret,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_next,
    output logic            pc_valid,
    output logic            halted,
    output logic            redir_pending,
    output logic            ras_err
);

    pc_state_t       state;
    logic            pend_valid;
    logic [PC_W-1:0] pend_target;
    logic            advance;
    logic            ras_hit;
    logic [PC_W-1:0] ras_top;
    logic [PC_W-1:0] pc_seq;

    // STALL advances exactly like RUN once stall drops; only pc_valid tells them apart
    assign advance  = ((state == RUN) || (state == STALL)) && !stall && !halt_req;
    assign pc_valid = (state == RUN) && !stall && !halt_req;
    assign pc_seq   = pc + PC_W'(STEP);
    assign redir_pending = pend_valid;

`ifdef PC_RAS_EN
    logic ras_push;
    logic ras_pop;
    logic ras_empty;
    logic unused_ras_full;

    assign ras_push = advance && call && redir_valid;
    assign ras_pop  = advance && ret && !call && !redir_valid;
    assign ras_hit  = ras_pop && !ras_empty;

    pc_ras #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_seq),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (unused_ras_full),
        .err   (ras_err)
    );
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    logic unused_ras_in;

    assign unused_ras_in = &{1'b0, call, ret};
    assign ras_hit = 1'b0;
    assign ras_top = '0;
    assign ras_err = 1'b0;
`endif

    always_comb begin
        pc_next = pc;
        if (advance) begin
            if (redir_valid) begin
                pc_next = redir_target;
            end else if (ras_hit) begin
                pc_next = ras_top;
            end else if (pend_valid) begin
                pc_next = pend_target;
            end else begin
                pc_next = pc_seq;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_VEC;
            state       <= RUN;
            halted      <= 1'b0;
            pend_valid  <= 1'b0;
            pend_target <= '0;
        end else begin
            pc <= pc_next;
            if (advance) begin
                pend_valid <= 1'b0;
            end else if (redir_valid) begin
                pend_valid  <= 1'b1;
                pend_target <= redir_target;
            end
            case (state)
                RUN: begin
                    if (halt_req) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (stall) begin
                        state <= STALL;
                    end
                end
                STALL: begin
                    if (halt_req) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else if (!stall) begin
                        state <= RUN;
                    end
                end
                HALT: begin
                    if (resume && !halt_req) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus random traffic against a queue-based reference model.
module tb_pc_unit;

`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif
    localparam int RAS_D = 2;

    logic        clk = 1'b0;
    logic        reset, stall, halt_req, resume, redir_valid, call, ret;
    logic [31:0] redir_target;
    logic [31:0] pc, pc_next, pc_w, pc_next_w;
    logic        pc_valid, halted, redir_pending, ras_err;
    logic        pc_valid_w, halted_w, redir_pending_w, ras_err_w;

    int n_checks = 0;
    int n_err    = 0;

    // reference model state
    logic [31:0] m_pc, m_pt;
    logic        m_pv, m_halt, m_held, m_err;
    logic [31:0] m_ras[$];

    always #5 clk = ~clk;

    pc_unit #(.RAS_DEPTH(RAS_D)) dut (
        .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req), .resume(resume),
        .redir_valid(redir_valid), .redir_target(redir_target), .call(call), .ret(ret),
        .pc(pc), .pc_next(pc_next), .pc_valid(pc_valid), .halted(halted),
        .redir_pending(redir_pending), .ras_err(ras_err)
    );

    pc_unit #(.RESET_VEC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req), .resume(resume),
        .redir_valid(redir_valid), .redir_target(redir_target), .call(call), .ret(ret),
        .pc(pc_w), .pc_next(pc_next_w), .pc_valid(pc_valid_w), .halted(halted_w),
        .redir_pending(redir_pending_w), .ras_err(ras_err_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] predict();
        logic [31:0] nx;
        nx = m_pc;
        if (!m_halt && !stall && !halt_req) begin
            if (redir_valid)                                       nx = redir_target;
            else if (RAS_ON && ret && !call && m_ras.size() > 0)   nx = m_ras[m_ras.size()-1];
            else if (m_pv)                                         nx = m_pt;
            else                                                   nx = m_pc + 32'd4;
        end
        return nx;
    endfunction

    task automatic commit(input logic [31:0] nx);
        logic adv;
        adv = !m_halt && !stall && !halt_req;
        if (reset) begin
            m_pc = 32'h0; m_pt = 32'h0; m_pv = 1'b0;
            m_halt = 1'b0; m_held = 1'b0; m_err = 1'b0;
            m_ras.delete();
            return;
        end
        m_err = 1'b0;
        if (adv) begin
            if (RAS_ON && call && redir_valid) begin
                m_ras.push_back(m_pc + 32'd4);
                if (m_ras.size() > RAS_D) begin
                    void'(m_ras.pop_front());
                    m_err = 1'b1;
                end
            end else if (RAS_ON && ret && !call && !redir_valid) begin
                if (m_ras.size() > 0) void'(m_ras.pop_back());
                else m_err = 1'b1;
            end
            m_pv = 1'b0;
        end else if (redir_valid) begin
            m_pv = 1'b1;
            m_pt = redir_target;
        end
        m_pc = nx;
        if (m_halt) begin
            if (resume && !halt_req) m_halt = 1'b0;
            m_held = 1'b0;
        end else if (halt_req) begin
            m_halt = 1'b1;
            m_held = 1'b0;
        end else begin
            m_held = stall;
        end
    endtask

    // called at a falling edge; returns at the next falling edge
    task automatic drive(input logic r, input logic st, input logic h, input logic rs,
                         input logic rv, input logic [31:0] t, input logic c, input logic rt);
        logic [31:0] nx;
        reset = r; stall = st; halt_req = h; resume = rs;
        redir_valid = rv; redir_target = t; call = c; ret = rt;
        #1;
        nx = predict();
        check("pc", pc, m_pc);
        check("halted", {31'd0, halted}, {31'd0, m_halt});
        check("redir_pending", {31'd0, redir_pending}, {31'd0, m_pv});
        check("ras_err", {31'd0, ras_err}, {31'd0, m_err});
        check("pc_next", pc_next, nx);
        check("pc_valid", {31'd0, pc_valid}, {31'd0, !m_halt && !m_held && !stall && !halt_req});
        commit(nx);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic redir(input logic [31:0] t);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, t, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        m_pc = 32'h0; m_pt = 32'h0; m_pv = 1'b0; m_halt = 1'b0; m_held = 1'b0; m_err = 1'b0;
        reset = 1'b1; stall = 1'b0; halt_req = 1'b0; resume = 1'b0;
        redir_valid = 1'b0; redir_target = 32'h0; call = 1'b0; ret = 1'b0;
        @(negedge clk);

        // reset state and free-running increment, plus wrap on the second instance
        do_reset();
        check("tp_rst_pc", pc, 32'h0);
        check("tp_rst_halted", {31'd0, halted}, 32'd0);
        check("tp_wrap0", pc_w, 32'hFFFF_FFF8);
        idle();
        check("tp_run1", pc, 32'h4);
        check("tp_wrap1", pc_w, 32'hFFFF_FFFC);
        idle();
        check("tp_run2", pc, 32'h8);
        check("tp_wrap2", pc_w, 32'h0000_0000);
        idle();
        check("tp_run3", pc, 32'hC);
        check("tp_valid", {31'd0, pc_valid}, 32'd1);

        // stall with a redirect arriving mid-stall
        redir(32'h10);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("tp_stall_pc", pc, 32'h10);
        check("tp_stall_pend", {31'd0, redir_pending}, 32'd1);
        idle();
        check("tp_stall_apply", pc, 32'h80);
        check("tp_stall_clear", {31'd0, redir_pending}, 32'd0);

        // halt, redirect while halted, resume
        redir(32'h20);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("tp_halted", {31'd0, halted}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
        check("tp_halt_pc", pc, 32'h20);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("tp_resume_pc", pc, 32'h20);
        check("tp_resume_halted", {31'd0, halted}, 32'd0);
        idle();
        check("tp_resume_apply", pc, 32'h40);

        // plain redirect latency
        redir(32'h100);
        redir(32'h200);
        check("tp_redir", pc, 32'h200);

        // return-address stack; without it, ret is ignored and pc keeps stepping
        do_reset();
        redir(32'h10);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("tp_ret", pc, RAS_ON ? 32'h14 : 32'h84);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0);
        check("tp_call2_err", {31'd0, ras_err}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 1'b0);
        check("tp_call3_err", {31'd0, ras_err}, {31'd0, RAS_ON});
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("tp_empty_ret_pc", pc, 32'h4);
        check("tp_empty_ret_err", {31'd0, ras_err}, {31'd0, RAS_ON});

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(63) == 0,
                  $urandom_range(3) == 0,
                  $urandom_range(7) == 0,
                  $urandom_range(3) == 0,
                  $urandom_range(4) == 0,
                  $urandom & 32'hFFFF_FFFC,
                  $urandom_range(3) == 0,
                  $urandom_range(3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
